// File: rtl/bram_dwc_wcb.sv
// Narrow-master to wide-slave BRAM data width converter with a one-line write-combining buffer.
// Partial master writes merge into one wide line; reads see pending bytes through a return-path overlay.
module bram_dwc_wcb #(
    parameter  int ADDR_BITW     = 32,
    parameter  int MST_DATA_BITW = 32,
    parameter  int SLV_DATA_BITW = 96,
    parameter  int RD_LATENCY    = 1,
    parameter  int FLUSH_TIMEOUT = 4,
    localparam int MST_BYTES     = MST_DATA_BITW / 8,
    localparam int SLV_BYTES     = SLV_DATA_BITW / 8
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RI,
    input  logic                     MstEn_SI,
    input  logic [ADDR_BITW-1:0]     MstAddr_SI,
    input  logic [MST_BYTES-1:0]     MstWrEn_SI,
    input  logic [MST_DATA_BITW-1:0] MstWr_DI,
    output logic [MST_DATA_BITW-1:0] MstRd_DO,
    output logic                     SlvEn_SO,
    output logic [ADDR_BITW-1:0]     SlvAddr_SO,
    output logic [SLV_BYTES-1:0]     SlvWrEn_SO,
    output logic [SLV_DATA_BITW-1:0] SlvWr_DO,
    input  logic [SLV_DATA_BITW-1:0] SlvRd_DI,
    input  logic                     Flush_SI,
    output logic                     Pending_SO
);

    localparam int RATIO  = SLV_DATA_BITW / MST_DATA_BITW;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CNT_W  = $clog2(FLUSH_TIMEOUT + 1);

    typedef struct packed {
        logic                     valid;
        logic [LANE_W-1:0]        lane;
        logic [SLV_DATA_BITW-1:0] data;
        logic [SLV_BYTES-1:0]     mask;
    } rd_pipe_t;

    logic [SLV_DATA_BITW-1:0] buf_d;
    logic [SLV_BYTES-1:0]     buf_be;
    logic [ADDR_BITW-1:0]     buf_line;
    logic [CNT_W-1:0]         idle_cnt;
    rd_pipe_t                 rd_pipe [RD_LATENCY];

    logic [ADDR_BITW-1:0]     mst_word;
    logic [ADDR_BITW-1:0]     mst_line;
    logic [LANE_W-1:0]        mst_lane;
    logic                     pending;
    logic                     mst_wr;
    logic                     mst_rd;
    logic                     same_line;
    logic                     line_hit;
    logic                     flush_free;
    logic [SLV_BYTES-1:0]     wr_be_wide;
    logic [SLV_DATA_BITW-1:0] wr_d_wide;
    logic [SLV_DATA_BITW-1:0] buf_d_merged;
    logic [SLV_DATA_BITW-1:0] rd_merged;
    rd_pipe_t                 rd_in;
    rd_pipe_t                 rd_head;

    // Constant divisors, so RATIO and MST_BYTES need not be powers of two.
    assign mst_word   = MstAddr_SI / ADDR_BITW'(MST_BYTES);
    assign mst_line   = mst_word / ADDR_BITW'(RATIO);
    assign mst_lane   = LANE_W'(mst_word % ADDR_BITW'(RATIO));

    assign pending    = |buf_be;
    assign mst_wr     = MstEn_SI & (|MstWrEn_SI);
    assign mst_rd     = MstEn_SI & ~(|MstWrEn_SI);
    assign same_line  = (mst_line == buf_line);
    assign line_hit   = pending & same_line;
    assign flush_free = !MstEn_SI && pending &&
                        (Flush_SI || idle_cnt >= CNT_W'(FLUSH_TIMEOUT - 1));
    assign Pending_SO = pending & ~Rst_RI;
    assign rd_head    = rd_pipe[RD_LATENCY-1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_be_wide = '0;
        wr_d_wide  = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (mst_lane == LANE_W'(i)) begin
                wr_be_wide[i*MST_BYTES +: MST_BYTES]         = MstWrEn_SI;
                wr_d_wide[i*MST_DATA_BITW +: MST_DATA_BITW] = MstWr_DI;
            end
        end
        buf_d_merged = buf_d;
        for (int b = 0; b < SLV_BYTES; b++) begin
            if (wr_be_wide[b]) buf_d_merged[b*8 +: 8] = wr_d_wide[b*8 +: 8];
        end
    end

    // A read to the pending line doubles as its flush; the captured bytes overlay the return.
    always_comb begin
        SlvEn_SO   = 1'b0;
        SlvAddr_SO = '0;
        SlvWrEn_SO = '0;
        SlvWr_DO   = '0;
        if (!Rst_RI) begin
            if (mst_rd) begin
                SlvEn_SO   = 1'b1;
                SlvAddr_SO = mst_line * ADDR_BITW'(SLV_BYTES);
                if (line_hit) begin
                    SlvWrEn_SO = buf_be;
                    SlvWr_DO   = buf_d;
                end
            end else if ((mst_wr && pending && !same_line) || flush_free) begin
                SlvEn_SO   = 1'b1;
                SlvAddr_SO = buf_line * ADDR_BITW'(SLV_BYTES);
                SlvWrEn_SO = buf_be;
                SlvWr_DO   = buf_d;
            end
        end
    end

    always_comb begin
        rd_in       = '0;
        rd_in.valid = mst_rd;
        rd_in.lane  = mst_lane;
        rd_in.data  = buf_d;
        rd_in.mask  = line_hit ? buf_be : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            buf_d    <= '0;
            buf_be   <= '0;
            buf_line <= '0;
            idle_cnt <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
        end else begin
            if (mst_wr) begin
                buf_line <= mst_line;
                buf_d    <= buf_d_merged;
                buf_be   <= (pending && !same_line) ? wr_be_wide : (buf_be | wr_be_wide);
                idle_cnt <= '0;
            end else if (mst_rd) begin
                if (line_hit) buf_be <= '0;
                idle_cnt <= '0;
            end else if (flush_free) begin
                buf_be   <= '0;
                idle_cnt <= '0;
            end else if (pending && idle_cnt != CNT_W'(FLUSH_TIMEOUT)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            rd_pipe[0] <= rd_in;
            for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    always_comb begin
        rd_merged = SlvRd_DI;
        for (int b = 0; b < SLV_BYTES; b++) begin
            if (rd_head.mask[b]) rd_merged[b*8 +: 8] = rd_head.data[b*8 +: 8];
        end
        MstRd_DO = '0;
        if (!Rst_RI && rd_head.valid) begin
            for (int i = 0; i < RATIO; i++) begin
                if (rd_head.lane == LANE_W'(i))
                    MstRd_DO = rd_merged[i*MST_DATA_BITW +: MST_DATA_BITW];
            end
        end
    end

endmodule

// File: tb/tb_bram_dwc_wcb.sv
// Self-checking bench for bram_dwc_wcb (MST 32, SLV 96, RD_LATENCY 1, FLUSH_TIMEOUT 4).
// Read results go through a scoreboard queue; slave-side activity is checked each cycle.
module tb_bram_dwc_wcb;

    logic        Clk_CI = 1'b0;
    logic        Rst_RI = 1'b1;
    logic        MstEn_SI = 1'b0;
    logic [31:0] MstAddr_SI = '0;
    logic [3:0]  MstWrEn_SI = '0;
    logic [31:0] MstWr_DI = '0;
    logic [31:0] MstRd_DO;
    logic        SlvEn_SO;
    logic [31:0] SlvAddr_SO;
    logic [11:0] SlvWrEn_SO;
    logic [95:0] SlvWr_DO;
    logic [95:0] SlvRd_DI = '0;
    logic        Flush_SI = 1'b0;
    logic        Pending_SO;

    typedef struct {
        int          due;
        logic [95:0] slv;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t rd_q [$];
    int      cyc    = 0;
    int      n_cmp  = 0;
    int      n_err  = 0;

    bram_dwc_wcb dut (
        .Clk_CI     (Clk_CI),
        .Rst_RI     (Rst_RI),
        .MstEn_SI   (MstEn_SI),
        .MstAddr_SI (MstAddr_SI),
        .MstWrEn_SI (MstWrEn_SI),
        .MstWr_DI   (MstWr_DI),
        .MstRd_DO   (MstRd_DO),
        .SlvEn_SO   (SlvEn_SO),
        .SlvAddr_SO (SlvAddr_SO),
        .SlvWrEn_SO (SlvWrEn_SO),
        .SlvWr_DO   (SlvWr_DO),
        .SlvRd_DI   (SlvRd_DI),
        .Flush_SI   (Flush_SI),
        .Pending_SO (Pending_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // One cycle: drive master inputs at the falling edge, supply the slave return, check read data.
    task automatic step(input logic en, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic fl);
        @(negedge Clk_CI);
        cyc++;
        MstEn_SI   = en;
        MstAddr_SI = addr;
        MstWrEn_SI = be;
        MstWr_DI   = wd;
        Flush_SI   = fl;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) SlvRd_DI = rd_q[0].slv;
        else SlvRd_DI = {$urandom, $urandom, $urandom};
        #1;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            check("rd_data", MstRd_DO, rd_q[0].exp);
            void'(rd_q.pop_front());
        end else begin
            check("rd_idle", MstRd_DO, 32'h0);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                      input logic fl);
        step(1'b1, addr, be, wd, fl);
    endtask

    task automatic idle(input logic fl);
        step(1'b0, 32'h0, 4'h0, 32'h0, fl);
    endtask

    // Issue a read; the slave returns slv one cycle later and exp is the required master data.
    task automatic rd(input logic [31:0] addr, input logic [95:0] slv, input logic [31:0] exp);
        rd_exp_t e;
        step(1'b1, addr, 4'h0, 32'h0, 1'b0);
        e.due = cyc + 1;
        e.slv = slv;
        e.exp = exp;
        rd_q.push_back(e);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},   SlvEn_SO,   1'b0);
        check({tag, "_wren"}, SlvWrEn_SO, 12'h0);
    endtask

    task automatic check_slv(input string tag, input logic [31:0] addr, input logic [11:0] wren);
        check({tag, "_en"},   SlvEn_SO,   1'b1);
        check({tag, "_addr"}, SlvAddr_SO, addr);
        check({tag, "_wren"}, SlvWrEn_SO, wren);
    endtask

    initial begin
        // Reset state
        idle(1'b0);
        check_quiet("rst");
        check("rst_pend", Pending_SO, 1'b0);
        idle(1'b0);
        Rst_RI = 1'b0;

        // Combine two writes, then a different line forces the flush
        wr(32'h0, 4'hF, 32'hAAAAAAAA, 1'b0);
        check_quiet("comb_wr0");
        check("comb_pend0", Pending_SO, 1'b0);
        wr(32'h4, 4'hF, 32'hBBBBBBBB, 1'b0);
        check_quiet("comb_wr1");
        check("comb_pend1", Pending_SO, 1'b1);
        wr(32'hC, 4'hF, 32'hCCCCCCCC, 1'b0);
        check_slv("comb_flush", 32'h0, 12'h0FF);
        check("comb_data", SlvWr_DO, {32'h0, 32'hBBBBBBBB, 32'hAAAAAAAA});

        // Line 1 now pending; timeout flush on the 4th free cycle
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check_quiet("to1_wait");
        end
        idle(1'b0);
        check_slv("to1_flush", 32'hC, 12'h00F);
        check("to1_data", SlvWr_DO[31:0], 32'hCCCCCCCC);
        idle(1'b0);
        check("to1_pend", Pending_SO, 1'b0);
        check_quiet("to1_after");

        // Timeout with a partial write to lane 2
        wr(32'h8, 4'h3, 32'h11223344, 1'b0);
        check_quiet("to2_wr");
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check_quiet("to2_wait");
            check("to2_pend", Pending_SO, 1'b1);
        end
        idle(1'b0);
        check_slv("to2_flush", 32'h0, 12'h300);
        check("to2_data", SlvWr_DO[79:64], 16'h3344);
        idle(1'b0);
        check("to2_pend_drop", Pending_SO, 1'b0);
        check_quiet("to2_after");

        // Forwarding: read to the pending line flushes and overlays
        wr(32'h4, 4'hF, 32'hDEADBEEF, 1'b0);
        check_quiet("fwd_wr");
        rd(32'h4, 96'h0, 32'hDEADBEEF);
        check_slv("fwd_rd", 32'h0, 12'h0F0);
        check("fwd_wdata", SlvWr_DO[63:32], 32'hDEADBEEF);
        idle(1'b0);
        check("fwd_pend", Pending_SO, 1'b0);
        check_quiet("fwd_after");

        // Partial forwarding: only the two buffered bytes replace slave data
        wr(32'h4, 4'h3, 32'h11225566, 1'b0);
        rd(32'h4, 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 32'hBBBB5566);
        check_slv("pfwd_rd", 32'h0, 12'h030);
        idle(1'b0);
        check("pfwd_pend", Pending_SO, 1'b0);

        // Other-line read leaves the buffer alone
        wr(32'h0, 4'hF, 32'h12345678, 1'b0);
        rd(32'h10, 96'h11111111_22222222_33333333, 32'h22222222);
        check_slv("oth_rd", 32'hC, 12'h000);

        // Write to line 2 flushes line 0; Flush_SI ignored during accesses
        wr(32'h18, 4'hF, 32'h55555555, 1'b1);
        check_slv("fl_evict", 32'h0, 12'h00F);
        check("fl_evict_data", SlvWr_DO[31:0], 32'h12345678);
        wr(32'h1C, 4'hF, 32'h66666666, 1'b1);
        check_quiet("fl_ignored");
        check("fl_pend", Pending_SO, 1'b1);
        idle(1'b1);
        check_slv("fl_flush", 32'h18, 12'h0FF);
        check("fl_data", SlvWr_DO[63:0], 64'h66666666_55555555);
        idle(1'b1);
        check("fl_pend_drop", Pending_SO, 1'b0);
        check_quiet("fl_empty");
        idle(1'b0);

        // Reset with a pending line discards it
        wr(32'h0, 4'hF, 32'h77777777, 1'b0);
        idle(1'b0);
        check("rst6_pend", Pending_SO, 1'b1);
        Rst_RI = 1'b1;
        idle(1'b1);
        check_quiet("rst6_free");
        check("rst6_pend_rst", Pending_SO, 1'b0);
        wr(32'h4, 4'hF, 32'h88888888, 1'b0);
        check_quiet("rst6_wr");
        check("rst6_addr", SlvAddr_SO, 32'h0);
        check("rst6_wdata", SlvWr_DO, 96'h0);
        idle(1'b0);
        Rst_RI = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            check_quiet("rst6_after");
            check("rst6_pend_after", Pending_SO, 1'b0);
        end

        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
